// File: rtl/fp_recip_seq_if.sv
// Handshake bundle for the sequential floating-point reciprocal unit.
// Operand channel (valid/ready) in, result channel (valid/ready) out.
interface fp_recip_seq_if #(
   parameter int unsigned NEXP = 8,
   parameter int unsigned NSIG = 7,
   parameter int unsigned TAGW = 4
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [NEXP+NSIG:0]   in_a;
   logic [1:0]           in_rm;
   logic [TAGW-1:0]      in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [NEXP+NSIG:0]   out_r;
   logic [5:0]           out_class;
   logic [4:0]           out_exc;
   logic [TAGW-1:0]      out_tag;

   modport master (
      output in_valid, in_a, in_rm, in_tag, out_ready,
      input  in_ready, out_valid, out_r, out_class, out_exc, out_tag
   );

   modport slave (
      input  in_valid, in_a, in_rm, in_tag, out_ready,
      output in_ready, out_valid, out_r, out_class, out_exc, out_tag
   );
endinterface

// File: rtl/fp_recip_seq.sv
// Sequential IEEE-style reciprocal 1/a: restoring radix-2 division of 1.0 by the
// normalised significand, then denormalisation and directed/RNE rounding.
module fp_recip_seq #(
   parameter int unsigned NEXP = 8,
   parameter int unsigned NSIG = 7,
   parameter int unsigned TAGW = 4
) (
   input logic           clk,
   input logic           rst_n,
   fp_recip_seq_if.slave bus
);
   localparam int unsigned W  = NEXP + NSIG + 1;
   localparam int unsigned XW = NSIG + 3;
   localparam int unsigned EW = NEXP + 3;
   localparam int unsigned CW = $clog2(NSIG + 3);
   localparam logic [CW-1:0]        LAST  = CW'(NSIG + 2);
   localparam logic signed [EW-1:0] BIAS2 = EW'(2 * ((1 << (NEXP - 1)) - 1));
   localparam logic signed [EW-1:0] EMAX  = EW'((1 << NEXP) - 1);

   typedef enum logic [1:0] {StIdle, StIter, StRound, StDone} state_e;
   typedef enum logic [2:0] {KFin, KQnan, KSnan, KZero, KInf} kind_e;

   state_e               state_q, state_d;
   kind_e                kind_q, kind_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 sign_q, sign_d;
   logic [1:0]           rm_q, rm_d;
   logic [TAGW-1:0]      tag_q, tag_d;
   logic [NSIG:0]        m_q, m_d;
   logic [XW-1:0]        rem_q, rem_d, quo_q, quo_d, x_q, x_d;
   logic signed [EW-1:0] be_q, be_d;
   logic                 stk_q, stk_d, tiny_q, tiny_d;
   logic                 out_valid_q, out_valid_d;
   logic [W-1:0]         out_r_q, out_r_d;
   logic [5:0]           out_class_q, out_class_d;
   logic [4:0]           out_exc_q, out_exc_d;
   logic [TAGW-1:0]      out_tag_q, out_tag_d;

   logic [NEXP-1:0]      a_exp;
   logic [NSIG-1:0]      a_frac;
   logic [CW-1:0]        lz;
   logic signed [EW-1:0] be_n, be_f;
   logic [XW-1:0]        xn;
   logic [EW-1:0]        sh;
   logic [2*XW-1:0]      wide;
   logic [NSIG:0]        sig;
   logic [NSIG+1:0]      sig_r;
   logic [NSIG-1:0]      frac_f;
   logic                 g, rb, inx, up, ovf, to_inf;
   logic [W-1:0]         res;
   logic [5:0]           cls;
   logic [4:0]           exc;

   function automatic logic [CW-1:0] lzc(input logic [NSIG-1:0] f);
      logic [CW-1:0] n;
      n = CW'(NSIG);
      for (int i = 0; i < NSIG; i++) if (f[i]) n = CW'(NSIG - 1 - i);
      return n;
   endfunction

   assign a_exp  = bus.in_a[W-2:NSIG];
   assign a_frac = bus.in_a[NSIG-1:0];
   assign lz     = lzc(a_frac);

   // Quotient below 1.0 (m > 1) needs a one-bit left shift and exponent decrement.
   always_comb begin
      be_n = quo_q[XW-1] ? be_q : be_q - EW'(1);
      xn   = quo_q[XW-1] ? quo_q : {quo_q[XW-2:0], 1'b0};
      sh   = EW'(1) - be_n;
      if (sh > EW'(XW)) sh = EW'(XW);
      wide = {xn, {XW{1'b0}}} >> sh;
   end

   always_comb begin
      sig = x_q[XW-1:2];
      g   = x_q[1];
      rb  = x_q[0];
      inx = g | rb | stk_q;
      unique case (rm_q)
         2'd0:    up = g & (rb | stk_q | sig[0]);
         2'd1:    up = 1'b0;
         2'd2:    up = ~sign_q & inx;
         default: up = sign_q & inx;
      endcase
      sig_r  = {1'b0, sig} + {{(NSIG + 1){1'b0}}, up};
      frac_f = sig_r[NSIG-1:0];
      be_f   = be_q;
      if (be_q == '0) begin
         be_f = sig_r[NSIG] ? EW'(1) : '0;
      end else if (sig_r[NSIG+1]) begin
         be_f   = be_q + EW'(1);
         frac_f = sig_r[NSIG:1];
      end
      ovf    = (be_f >= EMAX);
      to_inf = (rm_q == 2'd0) | ((rm_q == 2'd2) & ~sign_q) | ((rm_q == 2'd3) & sign_q);

      res = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG - 1){1'b0}}};
      cls = 6'b010000;
      exc = 5'b00000;
      unique case (kind_q)
         KQnan: ;
         KSnan: exc = 5'b00001;
         KZero: begin
            res = {sign_q, {NEXP{1'b1}}, {NSIG{1'b0}}};
            cls = 6'b001000;
            exc = 5'b00010;
         end
         KInf: begin
            res = {sign_q, {(W - 1){1'b0}}};
            cls = 6'b000100;
         end
         default: begin
            if (ovf) begin
               exc = 5'b10100;
               if (to_inf) begin
                  res = {sign_q, {NEXP{1'b1}}, {NSIG{1'b0}}};
                  cls = 6'b001000;
               end else begin
                  res = {sign_q, {(NEXP - 1){1'b1}}, 1'b0, {NSIG{1'b1}}};
                  cls = 6'b000001;
               end
            end else begin
               res = {sign_q, be_f[NEXP-1:0], frac_f};
               exc = {inx, tiny_q & inx, 3'b000};
               if (be_f == '0) cls = (frac_f == '0) ? 6'b000100 : 6'b000010;
               else            cls = 6'b000001;
            end
         end
      endcase
   end

   always_comb begin
      state_d = state_q;  kind_d = kind_q;  cnt_d = cnt_q;   sign_d = sign_q;
      rm_d    = rm_q;     tag_d  = tag_q;   m_d   = m_q;     rem_d  = rem_q;
      quo_d   = quo_q;    x_d    = x_q;     be_d  = be_q;    stk_d  = stk_q;
      tiny_d  = tiny_q;
      out_valid_d = out_valid_q;  out_r_d   = out_r_q;    out_class_d = out_class_q;
      out_exc_d   = out_exc_q;    out_tag_d = out_tag_q;
      unique case (state_q)
         StIdle: if (bus.in_valid) begin
            sign_d = bus.in_a[W-1];
            rm_d   = bus.in_rm;
            tag_d  = bus.in_tag;
            cnt_d  = '0;
            quo_d  = '0;
            rem_d  = XW'(1) << NSIG;
            state_d = StRound;
            if (a_exp == '1) begin
               kind_d = (a_frac == '0) ? KInf : (a_frac[NSIG-1] ? KQnan : KSnan);
            end else if (a_exp == '0 && a_frac == '0) begin
               kind_d = KZero;
            end else begin
               kind_d  = KFin;
               state_d = StIter;
               if (a_exp != '0) begin
                  m_d  = {1'b1, a_frac};
                  be_d = BIAS2 - EW'(a_exp);
               end else begin
                  m_d  = {1'b0, a_frac} << (lz + CW'(1));
                  be_d = BIAS2 + EW'(lz);
               end
            end
         end
         StIter: begin
            if (rem_q >= XW'(m_q)) begin
               quo_d = {quo_q[XW-2:0], 1'b1};
               rem_d = (rem_q - XW'(m_q)) << 1;
            end else begin
               quo_d = {quo_q[XW-2:0], 1'b0};
               rem_d = rem_q << 1;
            end
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = StRound;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StRound: begin
            // Cycle 0 aligns and denormalises; cycle 1 rounds and loads outputs.
            if (cnt_q == '0) begin
               cnt_d = CW'(1);
               if (be_n <= 0) begin
                  x_d    = wide[2*XW-1:XW];
                  stk_d  = (|rem_q) | (|wide[XW-1:0]);
                  be_d   = '0;
                  tiny_d = 1'b1;
               end else begin
                  x_d    = xn;
                  stk_d  = |rem_q;
                  be_d   = be_n;
                  tiny_d = 1'b0;
               end
            end else begin
               cnt_d       = '0;
               state_d     = StDone;
               out_valid_d = 1'b1;
               out_r_d     = res;
               out_class_d = cls;
               out_exc_d   = exc;
               out_tag_d   = tag_q;
            end
         end
         StDone: if (bus.out_ready) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;  kind_q <= KFin;  cnt_q <= '0;  sign_q <= 1'b0;
         rm_q    <= '0;      tag_q  <= '0;    m_q   <= '0;  rem_q  <= '0;
         quo_q   <= '0;      x_q    <= '0;    be_q  <= '0;  stk_q  <= 1'b0;
         tiny_q  <= 1'b0;
         out_valid_q <= 1'b0;  out_r_q <= '0;  out_class_q <= '0;
         out_exc_q   <= '0;    out_tag_q <= '0;
      end else begin
         state_q <= state_d;  kind_q <= kind_d;  cnt_q <= cnt_d;  sign_q <= sign_d;
         rm_q    <= rm_d;     tag_q  <= tag_d;   m_q   <= m_d;    rem_q  <= rem_d;
         quo_q   <= quo_d;    x_q    <= x_d;     be_q  <= be_d;   stk_q  <= stk_d;
         tiny_q  <= tiny_d;
         out_valid_q <= out_valid_d;  out_r_q <= out_r_d;  out_class_q <= out_class_d;
         out_exc_q   <= out_exc_d;    out_tag_q <= out_tag_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = out_valid_q;
   assign bus.out_r     = out_r_q;
   assign bus.out_class = out_class_q;
   assign bus.out_exc   = out_exc_q;
   assign bus.out_tag   = out_tag_q;
endmodule

// File: doc/fp_recip_seq.md
FP_RECIP_SEQ -- requirements
Module: fp_recip_seq

Interface
REQ-001 Parameter NEXP, default 8, exponent field width.
REQ-002 Parameter NSIG, default 7, stored fraction width; the 8/7 defaults give bf16.
REQ-003 Parameter TAGW, default 4, width of the opaque tag carried from input to output.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  operand offered.
REQ-008 in_ready  out  1  block can accept an operand.
REQ-009 in_a  in  NEXP+NSIG+1  operand, packed as {sign, exp, frac}.
REQ-010 in_rm  in  2  rounding mode: 0=RNE, 1=RTZ, 2=RUP, 3=RDN.
REQ-011 in_tag  in  TAGW  opaque tag.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 out_r  out  NEXP+NSIG+1  reciprocal 1/in_a.
REQ-015 out_class  out  6  one-hot class of the result: [0]NORMAL [1]SUBNORMAL [2]ZERO [3]INFINITY [4]QNAN [5]SNAN.
REQ-016 out_exc  out  5  exception flags: [0]INVALID [1]DIVIDEBYZERO [2]OVERFLOW [3]UNDERFLOW [4]INEXACT.
REQ-017 out_tag  out  TAGW  tag captured with the operand.

Function
REQ-018 The FSM SHALL have four states, IDLE, ITER, ROUND and DONE. in_ready SHALL equal (state==IDLE), so at most one operation is in flight.
REQ-019 Accept occurs when in_valid && in_ready. On accept, in_a, in_rm and in_tag SHALL be registered; later changes on these inputs SHALL have no effect.
REQ-020 Special operands SHALL go IDLE->ROUND->DONE, giving out_valid 2 cycles after the accept edge.
REQ-021 Special operand qNaN: result is canonical qNaN {0, all-ones exp, frac MSB=1, rest 0}; no flags.
REQ-022 Special operand sNaN: result is the same canonical qNaN with INVALID set.
REQ-023 Special operand ±0: result is ±inf with DIVIDEBYZERO set.
REQ-024 Special operand ±inf: result is ±0; no flags.
REQ-025 Finite nonzero operands SHALL be normalised at accept. Subnormals SHALL be normalised via a leading-zero count to a significand m in [1,2) and an unbiased exponent e.
REQ-026 ITER SHALL run radix-2 restoring division of 1.0 by m. It SHALL last exactly NSIG+3 cycles, producing one quotient bit per cycle (NSIG+1 result bits plus guard and round), counted by an internal counter that wraps to 0 on exit.
REQ-027 Sticky SHALL be the OR of the final remainder bits.
REQ-028 Normalisation: if m==1.0, the unbiased result exponent SHALL be -e; otherwise the quotient is shifted left by 1 and the exponent is -e-1.
REQ-029 A biased result exponent <=0 SHALL produce a denormalised significand, right-shifted with all shifted-out bits ORed into sticky.
REQ-030 ROUND SHALL apply in_rm to guard/round/sticky. Rounding carry-out SHALL renormalise, including subnormal->normal promotion.
REQ-031 INEXACT SHALL be set when guard|round|sticky is nonzero.
REQ-032 OVERFLOW (with INEXACT) SHALL be set when the rounded exponent reaches all-ones. The result is then inf for RNE, RUP(+) or RDN(-), and max finite otherwise.
REQ-033 UNDERFLOW SHALL be set only when the result is tiny before rounding and INEXACT.
REQ-034 A finite nonzero operand SHALL produce out_valid exactly NSIG+5 cycles after the accept edge (12 for bf16).
REQ-035 In DONE, out_valid=1, and out_r, out_class, out_exc and out_tag SHALL hold stable until out_ready.
REQ-036 When out_valid && out_ready, the FSM SHALL go to IDLE on the next edge. The following operand SHALL NOT be accepted in that same cycle.
REQ-037 out_class SHALL be exactly one-hot whenever out_valid=1.

Reset
REQ-038 rst_n low SHALL immediately force the state to IDLE and the counter to 0.
REQ-039 rst_n low SHALL immediately force out_valid=0, out_r=0, out_class=0, out_exc=0 and out_tag=0.
REQ-040 in_ready SHALL be 1 once reset is released.
REQ-041 Reset asserted mid-ITER or in DONE SHALL discard the operation, and no stale out_valid SHALL appear.

Verification
REQ-042 bf16, in_a=0x3F80, RNE -> out_r=0x3F80, NORMAL, out_exc=0, out_valid at accept+12.
REQ-043 in_a=0x4040 (3.0), RNE -> out_r=0x3EAB, INEXACT only; with RTZ -> out_r=0x3EAA.
REQ-044 in_a=0x8000, then in_a=0xFF81 -> out_r=0xFF80 with DIVIDEBYZERO, then out_r=0x7FC0 with INVALID, each result at accept+2.
REQ-045 in_a=0x0001, RNE -> out_r=0x7F80 with OVERFLOW|INEXACT; with RTZ -> out_r=0x7F7F.
REQ-046 in_a=0x7F00 -> out_r=0x0040, SUBNORMAL, out_exc=0.
REQ-047 Hold out_ready=0 for 5 cycles with in_valid held high -> outputs and tag stable, in_ready=0. Then pulse rst_n low mid-ITER of the next operation -> out_valid stays 0 and in_ready returns to 1.
